riscv_scoreboard: RTL and testbench
===================================

RISCV_SCOREBOARD -- requirements
Module: riscv_scoreboard

Interface
REQ-001 Parameter RF_ADDR_WIDTH, default 5: register-file address width; NREGS = 2**RF_ADDR_WIDTH.
REQ-002 Parameter LAT_WIDTH, default 3: width of the per-register result-latency countdown.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 issue_valid  input  1  decoded instruction wants to advance ID->EX this cycle.
REQ-007 issue_rs1 / issue_rs2  input  RF_ADDR_WIDTH each  source registers.
REQ-008 issue_rs1_used / issue_rs2_used  input  1 each  source register is actually read.
REQ-009 issue_rd  input  RF_ADDR_WIDTH  destination register.
REQ-010 issue_we  input  1  instruction writes rd.
REQ-011 issue_lat  input  LAT_WIDTH  cycles until the result is forwardable (ALU 0, load 1, mul/div up to 2**LAT_WIDTH-1).
REQ-012 wb_valid / wb_rd  input  1 / RF_ADDR_WIDTH  register-file write retiring this cycle.
REQ-013 kill_valid / kill_rd  input  1 / RF_ADDR_WIDTH  in-flight writer squashed by flush.
REQ-014 stall  output  1  hold ID, inject bubble into EX.
REQ-015 busy  output  1  at least one register has a pending write.
REQ-016 pending  output  NREGS  per-register pending flag (inflight count != 0).

Function
REQ-017 Per register r SHALL hold inflight[r] (2 bits, 0..3) and cnt[r] (LAT_WIDTH bits); register 0 never tracked, always reads 0.
REQ-018 raw_hit SHALL be 1 if, for a used source s != 0, inflight[s] != 0 and cnt[s] != 0.
REQ-019 waw_full SHALL be 1 if issue_we, issue_rd != 0 and inflight[issue_rd] == 3.
REQ-020 stall SHALL be combinational: issue_valid & (raw_hit | waw_full); zero latency.
REQ-021 An issue is accepted when issue_valid & !stall; only accepted issues update state.
REQ-022 Accepted issue with issue_we and rd != 0: inflight[rd] += 1 and cnt[rd] <= issue_lat at next edge.
REQ-023 Every cycle, each cnt[r] != 0 not reloaded by REQ-022 SHALL decrement by 1, saturating at 0.
REQ-024 wb_valid with wb_rd != 0 SHALL decrement inflight[wb_rd]; kill_valid with kill_rd != 0 likewise.
REQ-025 Simultaneous increment and decrement(s) on one register SHALL net: inflight += 1 - (wb hit) - (kill hit).
REQ-026 A decrement of inflight already 0 SHALL leave it 0 and is a protocol error (assertion).
REQ-027 When inflight[r] becomes 0, cnt[r] SHALL be cleared to 0 the same edge.
REQ-028 A source equal to a same-cycle wb_rd SHALL still use current state (forwarding covers the WB case).
REQ-029 busy = OR of pending; pending[r] = (inflight[r] != 0), registered-state driven.

Reset
REQ-030 rst SHALL clear all inflight and cnt asynchronously; stall, busy, pending are 0 while rst is high.
REQ-031 Reset mid-countdown SHALL discard all pending state; first post-reset issue sees no hazards.

Structure
REQ-032 Shared package: RF_ADDR_WIDTH default, LAT_WIDTH default, latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MULDIV.
REQ-033 Natural sub-module: riscv_sb_entry (one register's inflight/cnt logic), instantiated NREGS-1 times via generate.
REQ-034 No memories; all state in flops; target 120-400 RTL lines.

Verification
REQ-035 Load x5 (lat 1), next cycle add reads x5 -> stall=1 one cycle, then 0; pending[5] clears on wb of x5.
REQ-036 ALU write x3 (lat 0), next cycle reads x3 -> stall=0; pending[3]=1 until wb_rd=3.
REQ-037 Div x7 lat 6, then three reads of x7 -> stall held 6 cycles, released cycle 7.
REQ-038 Three ALU writes x9 back-to-back, fourth write x9 before any wb -> stall=1 until first wb_rd=9.
REQ-039 Issue x4 and wb_rd=4 same cycle with inflight[4]=1 -> inflight stays 1; kill_rd=4 next -> pending[4]=0.
REQ-040 rst asserted with 5 registers pending, cnt mid-count -> pending=0, busy=0, stall=0 immediately.

Source files
------------

// File: rtl/riscv_scoreboard_pkg.sv
// riscv_scoreboard_pkg
// Shared constants for the register-file hazard scoreboard: default widths
// and the result latencies used by the issue stage when tagging writers.
package riscv_scoreboard_pkg;

   localparam int RF_ADDR_WIDTH_DEF = 5;
   localparam int LAT_WIDTH_DEF     = 3;

   // Cycles until a result is forwardable, counted from the issue edge.
   localparam int LAT_ALU    = 0;
   localparam int LAT_LOAD   = 1;
   localparam int LAT_MULDIV = 6;

   // Largest outstanding-writer count a register can track.
   localparam logic [1:0] INFLIGHT_MAX = 2'd3;

endpackage

// File: rtl/riscv_sb_entry.sv
// riscv_sb_entry
// Tracking state for one architectural register: how many writers are in
// flight and how many cycles remain before the youngest result is forwardable.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   inc           an accepted issue writes this register
//   dec_wb        a register-file write for this register retires
//   dec_kill      an in-flight writer of this register is squashed
//   lat           latency loaded into the countdown on inc
//   inflight      outstanding writer count (0..3)
//   cnt           remaining cycles before the result is forwardable
module riscv_sb_entry
   import riscv_scoreboard_pkg::*;
#(
   parameter int LAT_WIDTH = LAT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 dec_wb,
   input  logic                 dec_kill,
   input  logic [LAT_WIDTH-1:0] lat,
   output logic [1:0]           inflight,
   output logic [LAT_WIDTH-1:0] cnt
);

   logic [1:0]           inflight_q, inflight_d;
   logic [LAT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]           up;
   logic [2:0]           dn;
   logic [2:0]           diff;
   logic                 underflow;

   always_comb begin
      up        = {1'b0, inflight_q} + {2'b00, inc};
      dn        = {2'b00, dec_wb} + {2'b00, dec_kill};
      diff      = 3'd0;
      underflow = 1'b0;
      inflight_d = inflight_q;

      // Net the increment against both decrement sources; clamp at 0 on a
      // retire with nothing outstanding, and at the max as a safety net (the
      // WAW stall keeps an issue from arriving when already full).
      if (dn > up) begin
         underflow  = 1'b1;
         inflight_d = 2'd0;
      end else begin
         diff = up - dn;
         if (diff > {1'b0, INFLIGHT_MAX}) begin
            inflight_d = INFLIGHT_MAX;
         end else begin
            inflight_d = diff[1:0];
         end
      end

      if (inc) begin
         cnt_d = lat;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - LAT_WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end

      // No writer left means no result to wait on.
      if (inflight_d == 2'd0) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 2'd0;
         cnt_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
      end
   end

   assign inflight = inflight_q;
   assign cnt      = cnt_q;

   // Retiring or killing a writer that was never issued is a pipeline bug.
   a_no_underflow : assert property (@(posedge clk) disable iff (rst) !underflow);

endmodule

// File: rtl/riscv_scoreboard.sv
// riscv_scoreboard
// ID-stage hazard scoreboard. Tracks pending writes per register and raises
// stall when the decoded instruction reads a result that is not yet
// forwardable, or would exceed the writer count its destination can track.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   issue_valid                      instruction wants to advance ID->EX
//   issue_rs1/rs2, issue_rs*_used    source registers and read enables
//   issue_rd, issue_we, issue_lat    destination, write enable, result latency
//   wb_valid, wb_rd                  register-file write retiring this cycle
//   kill_valid, kill_rd              in-flight writer squashed by flush
//   stall                            hold ID, bubble EX (combinational)
//   busy                             any register has a pending write
//   pending                          per-register pending flag
module riscv_scoreboard
   import riscv_scoreboard_pkg::*;
#(
   parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
   parameter int LAT_WIDTH     = LAT_WIDTH_DEF,
   localparam int NREGS        = 2**RF_ADDR_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   input  logic [RF_ADDR_WIDTH-1:0] issue_rs1,
   input  logic [RF_ADDR_WIDTH-1:0] issue_rs2,
   input  logic                     issue_rs1_used,
   input  logic                     issue_rs2_used,
   input  logic [RF_ADDR_WIDTH-1:0] issue_rd,
   input  logic                     issue_we,
   input  logic [LAT_WIDTH-1:0]     issue_lat,
   input  logic                     wb_valid,
   input  logic [RF_ADDR_WIDTH-1:0] wb_rd,
   input  logic                     kill_valid,
   input  logic [RF_ADDR_WIDTH-1:0] kill_rd,
   output logic                     stall,
   output logic                     busy,
   output logic [NREGS-1:0]         pending
);

   logic [1:0]           inflight [NREGS];
   logic [LAT_WIDTH-1:0] cnt      [NREGS];
   logic                 raw_hit;
   logic                 waw_full;
   logic                 accept;
   logic                 wr_en;

   // x0 is hardwired; it never carries a hazard.
   assign inflight[0] = 2'd0;
   assign cnt[0]      = '0;

   genvar r;
   generate
      for (r = 1; r < NREGS; r++) begin : g_entry
         riscv_sb_entry #(
            .LAT_WIDTH (LAT_WIDTH)
         ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .inc      (wr_en && (issue_rd == RF_ADDR_WIDTH'(r))),
            .dec_wb   (wb_valid && (wb_rd == RF_ADDR_WIDTH'(r))),
            .dec_kill (kill_valid && (kill_rd == RF_ADDR_WIDTH'(r))),
            .lat      (issue_lat),
            .inflight (inflight[r]),
            .cnt      (cnt[r])
         );
      end
   endgenerate

   // Hazards look only at registered state: a same-cycle writeback is
   // covered by the forwarding path, not by clearing the stall early.
   always_comb begin
      raw_hit = 1'b0;
      if (issue_rs1_used && (issue_rs1 != '0) &&
          (inflight[issue_rs1] != 2'd0) && (cnt[issue_rs1] != '0)) begin
         raw_hit = 1'b1;
      end
      if (issue_rs2_used && (issue_rs2 != '0) &&
          (inflight[issue_rs2] != 2'd0) && (cnt[issue_rs2] != '0)) begin
         raw_hit = 1'b1;
      end

      waw_full = issue_we && (issue_rd != '0) && (inflight[issue_rd] == INFLIGHT_MAX);

      stall  = issue_valid && (raw_hit || waw_full) && !rst;
      accept = issue_valid && !stall;
      wr_en  = accept && issue_we && (issue_rd != '0);
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < NREGS; i++) begin
         pending[i] = (inflight[i] != 2'd0);
      end
   end

   assign busy = |pending;

endmodule

// File: tb/tb_riscv_scoreboard.sv
// tb_riscv_scoreboard
// Directed table of per-cycle stimulus with hand-computed stall/pending
// expectations, plus a hand-written reset-during-countdown sequence.
module tb_riscv_scoreboard;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_rs1_used, issue_rs2_used, issue_we;
   logic [2:0]  issue_lat;
   logic        wb_valid, kill_valid;
   logic [4:0]  wb_rd, kill_rd;
   logic        stall, busy;
   logic [31:0] pending;

   int checks;
   int failures;

   riscv_scoreboard #(
      .RF_ADDR_WIDTH (5),
      .LAT_WIDTH     (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .issue_valid    (issue_valid),
      .issue_rs1      (issue_rs1),
      .issue_rs2      (issue_rs2),
      .issue_rs1_used (issue_rs1_used),
      .issue_rs2_used (issue_rs2_used),
      .issue_rd       (issue_rd),
      .issue_we       (issue_we),
      .issue_lat      (issue_lat),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .kill_valid     (kill_valid),
      .kill_rd        (kill_rd),
      .stall          (stall),
      .busy           (busy),
      .pending        (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic [4:0]  rd;
      logic        we;
      logic [2:0]  lat;
      logic        wbv;
      logic [4:0]  wbr;
      logic        kv;
      logic [4:0]  kr;
      logic        exp_stall;
      logic [31:0] exp_pend;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t row(int iv, int rs1, int u1, int rs2, int u2, int rd, int we, int lat,
                                int wbv, int wbr, int kv, int kr, int st, logic [31:0] pend);
      vec_t v;
      v.iv = 1'(iv);  v.rs1 = 5'(rs1); v.u1 = 1'(u1); v.rs2 = 5'(rs2); v.u2 = 1'(u2);
      v.rd = 5'(rd);  v.we = 1'(we);   v.lat = 3'(lat);
      v.wbv = 1'(wbv); v.wbr = 5'(wbr); v.kv = 1'(kv); v.kr = 5'(kr);
      v.exp_stall = 1'(st); v.exp_pend = pend;
      return v;
   endfunction

   task automatic drive_idle();
      issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_used = 0; issue_rs2_used = 0;
      issue_rd = 0; issue_we = 0; issue_lat = 0; wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0;
   endtask

   task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      drive_idle();
      rst = 1'b1;

      // Reset state, with a hazard-shaped instruction presented.
      repeat (2) @(negedge clk);
      issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1; issue_rd = 5; issue_we = 1;
      #1;
      check("reset_stall", -1, {31'd0, stall}, 32'd0);
      check("reset_busy", -1, {31'd0, busy}, 32'd0);
      check("reset_pending", -1, pending, 32'd0);
      @(negedge clk);
      drive_idle();
      rst = 1'b0;

      // Load x5 lat 1 then dependent add.
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,0,0, 0,32'h0));
      vecs.push_back(row(1,0,0,0,0,5,1,1, 0,0,0,0, 0,32'h0));
      vecs.push_back(row(1,5,1,0,0,6,1,0, 0,0,0,0, 1,32'h20));
      vecs.push_back(row(1,5,1,0,0,6,1,0, 0,0,0,0, 0,32'h20));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 1,5,0,0, 0,32'h60));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 1,6,0,0, 0,32'h40));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,0,0, 0,32'h0));
      // ALU write x3, immediate reader forwards.
      vecs.push_back(row(1,0,0,0,0,3,1,0, 0,0,0,0, 0,32'h0));
      vecs.push_back(row(1,0,0,3,1,0,0,0, 0,0,0,0, 0,32'h8));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,0,0, 0,32'h8));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 1,3,0,0, 0,32'h8));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,0,0, 0,32'h0));
      // Div x7 lat 6, three reads: six stall cycles, released on the seventh.
      vecs.push_back(row(1,0,0,0,0,7,1,6, 0,0,0,0, 0,32'h0));
      for (int i = 0; i < 6; i++) vecs.push_back(row(1,7,1,0,0,0,0,0, 0,0,0,0, 1,32'h80));
      for (int i = 0; i < 3; i++) vecs.push_back(row(1,7,1,0,0,0,0,0, 0,0,0,0, 0,32'h80));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 1,7,0,0, 0,32'h80));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,0,0, 0,32'h0));
      // Four writers of x9: fourth stalls until the first wb of x9.
      vecs.push_back(row(1,0,0,0,0,9,1,0, 0,0,0,0, 0,32'h0));
      vecs.push_back(row(1,0,0,0,0,9,1,0, 0,0,0,0, 0,32'h200));
      vecs.push_back(row(1,0,0,0,0,9,1,0, 0,0,0,0, 0,32'h200));
      vecs.push_back(row(1,0,0,0,0,9,1,0, 0,0,0,0, 1,32'h200));
      vecs.push_back(row(1,0,0,0,0,9,1,0, 1,9,0,0, 1,32'h200));
      vecs.push_back(row(1,0,0,0,0,9,1,0, 0,0,0,0, 0,32'h200));
      for (int i = 0; i < 3; i++) vecs.push_back(row(0,0,0,0,0,0,0,0, 1,9,0,0, 0,32'h200));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,0,0, 0,32'h0));
      // Issue x4 with same-cycle wb of x4 nets to 1; kill then clears it.
      vecs.push_back(row(1,0,0,0,0,4,1,0, 0,0,0,0, 0,32'h0));
      vecs.push_back(row(1,0,0,0,0,4,1,0, 1,4,0,0, 0,32'h10));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,1,4, 0,32'h10));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,0,0, 0,32'h0));
      // x0 is never tracked.
      vecs.push_back(row(1,0,1,0,1,0,1,2, 0,0,0,0, 0,32'h0));
      vecs.push_back(row(1,0,1,0,1,0,0,0, 0,0,0,0, 0,32'h0));
      // Unused sources ignore hazards; rs2 path stalls.
      vecs.push_back(row(1,0,0,0,0,5,1,3, 0,0,0,0, 0,32'h0));
      vecs.push_back(row(1,5,0,5,0,0,0,0, 0,0,0,0, 0,32'h20));
      vecs.push_back(row(1,0,0,5,1,0,0,0, 0,0,0,0, 1,32'h20));
      vecs.push_back(row(1,0,0,5,1,0,0,0, 0,0,0,0, 1,32'h20));
      vecs.push_back(row(1,0,0,5,1,0,0,0, 0,0,0,0, 0,32'h20));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 1,5,0,0, 0,32'h20));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,0,0, 0,32'h0));
      // No stall without issue_valid; same-cycle wb still stalls; last wb clears cnt.
      vecs.push_back(row(1,0,0,0,0,10,1,5, 0,0,0,0, 0,32'h0));
      vecs.push_back(row(0,10,1,0,0,0,0,0, 0,0,0,0, 0,32'h400));
      vecs.push_back(row(1,10,1,0,0,0,0,0, 1,10,0,0, 1,32'h400));
      vecs.push_back(row(1,10,1,0,0,0,0,0, 0,0,0,0, 0,32'h0));
      // Issue plus wb plus kill on x11 from inflight 2 nets to 1.
      vecs.push_back(row(1,0,0,0,0,11,1,0, 0,0,0,0, 0,32'h0));
      vecs.push_back(row(1,0,0,0,0,11,1,0, 0,0,0,0, 0,32'h800));
      vecs.push_back(row(1,0,0,0,0,11,1,0, 1,11,1,11, 0,32'h800));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 1,11,0,0, 0,32'h800));
      vecs.push_back(row(0,0,0,0,0,0,0,0, 0,0,0,0, 0,32'h0));

      foreach (vecs[i]) begin
         @(negedge clk);
         issue_valid = vecs[i].iv; issue_rs1 = vecs[i].rs1; issue_rs1_used = vecs[i].u1;
         issue_rs2 = vecs[i].rs2; issue_rs2_used = vecs[i].u2; issue_rd = vecs[i].rd;
         issue_we = vecs[i].we; issue_lat = vecs[i].lat;
         wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbr; kill_valid = vecs[i].kv; kill_rd = vecs[i].kr;
         #1;
         check("stall", i, {31'd0, stall}, {31'd0, vecs[i].exp_stall});
         check("busy", i, {31'd0, busy}, {31'd0, (vecs[i].exp_pend != 32'd0)});
         check("pending", i, pending, vecs[i].exp_pend);
      end

      // Reset mid-countdown with five registers pending.
      for (int r = 1; r <= 5; r++) begin
         @(negedge clk);
         drive_idle();
         issue_valid = 1; issue_rd = 5'(r); issue_we = 1; issue_lat = 3'd7;
      end
      @(negedge clk);
      drive_idle();
      issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;
      #1;
      check("pre_rst_stall", -2, {31'd0, stall}, 32'd1);
      check("pre_rst_pending", -2, pending, 32'h3E);
      #1;
      rst = 1'b1;
      #1;
      check("rst_stall", -2, {31'd0, stall}, 32'd0);
      check("rst_busy", -2, {31'd0, busy}, 32'd0);
      check("rst_pending", -2, pending, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_stall", -2, {31'd0, stall}, 32'd0);
      @(negedge clk);
      drive_idle();
      #1;
      check("post_rst_pending", -2, pending, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
